video_plane_fetch: RTL and testbench

Parametrised bit-plane fetch and pixel serialiser. It is the successor to the fixed 4-plane framebuffer fetch used by `video`. During `video_slice` cycles it issues SRAM reads for every bit-plane of the current column and row. Each plane's byte goes into a ping-pong pair of shift registers. The block then emits a per-pixel colour index in 256-pixel (PLANES-bit) or 512-pixel (2-bit) mode, plus a delayed horizontal-border flag. It sits between the video timing generator (which supplies `hsync_n` and `fb_row`) and the palette/DAC stage.

---
 rtl/video_plane_fetch.sv | 130 +++++++++++++
 tb/tb_video_plane_fetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/video_plane_fetch.sv
`default_nettype none
// ============================================================================
// video_plane_fetch : bit-plane SRAM fetch with ping-pong pixel serialiser
// Rev 1.0
// ============================================================================
module video_plane_fetch #(
    parameter int PLANES       = 4,
    parameter int COLW         = 5,
    parameter int ROWW         = 8,
    parameter int HS_COL       = 26,
    parameter int BORDER_DELAY = 4
) (
    input  logic              clk24,
    input  logic              reset_n,
    input  logic              ce12,
    input  logic              video_slice,
    input  logic              hsync_n,
    input  logic [ROWW-1:0]   fb_row,
    input  logic              mode512,
    input  logic [7:0]        sram_dq,
    output logic [15:0]       sram_addr,
    output logic [PLANES-1:0] coloridx,
    output logic              borderx,
    output logic              phase
);

    localparam int c_PB = $clog2(PLANES);

    logic [c_PB:0]             r_slot;
    logic [COLW-1:0]           r_column;
    logic                      r_phase;
    logic                      r_border_raw;
    logic [BORDER_DELAY-1:0]   r_bdly;
    logic [PLANES-1:0]         r_wr;
    logic [15:0]               r_addr;
    logic [PLANES-1:0]         r_color;

    logic [PLANES-1:0]         w_pbit;
    logic [PLANES-1:0]         w_color_256;
    logic [PLANES-1:0]         w_color_512;
    logic                      w_group_end;

    assign w_group_end = video_slice && (r_slot == '1);

    // Two slots per plane; the even slot raises that plane's load strobe
    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            r_slot       <= '0;
            r_column     <= '0;
            r_phase      <= 1'b0;
            r_border_raw <= 1'b0;
            r_wr         <= '0;
            r_addr       <= '0;
        end else begin
            for (int p = 0; p < PLANES; p++) begin
                r_wr[p] <= video_slice && !r_slot[0] && (r_slot[c_PB:1] == c_PB'(p));
            end
            if (video_slice) begin
                r_slot <= r_slot + 1'b1;
                r_addr <= {1'b1, r_slot[c_PB:1], r_column, fb_row};
            end
            if (w_group_end) begin
                r_phase <= ~r_phase;
                if (r_column == '0) begin
                    r_border_raw <= ~r_border_raw;
                end
                if (!hsync_n) begin
                    r_column <= COLW'(HS_COL);
                end else begin
                    r_column <= r_column + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            r_bdly <= '0;
        end else begin
            r_bdly[0] <= r_border_raw;
            for (int i = 1; i < BORDER_DELAY; i++) begin
                r_bdly[i] <= r_bdly[i-1];
            end
        end
    end

    // Per-plane ping-pong: the loading bank never shifts
    for (genvar p = 0; p < PLANES; p++) begin : g_plane
        logic [7:0] r_sha;
        logic [7:0] r_shb;

        always_ff @(posedge clk24) begin
            if (!reset_n) begin
                r_sha <= '0;
                r_shb <= '0;
            end else if (r_phase) begin
                if (r_wr[p]) r_sha <= sram_dq;
                if (ce12)    r_shb <= {r_shb[6:0], 1'b0};
            end else begin
                if (r_wr[p]) r_shb <= sram_dq;
                if (ce12)    r_sha <= {r_sha[6:0], 1'b0};
            end
        end

        assign w_pbit[p]                 = r_phase ? r_shb[7] : r_sha[7];
        assign w_color_256[PLANES-1-p]   = w_pbit[p];
    end

    if (PLANES == 2) begin : g_c512_two
        assign w_color_512 = {w_pbit[1], w_pbit[0]};
    end else begin : g_c512_multi
        assign w_color_512 = {{(PLANES-2){1'b0}},
                              (ce12 ? {w_pbit[1], w_pbit[0]} : {w_pbit[2], w_pbit[3]})};
    end

    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            r_color <= '0;
        end else begin
            r_color <= mode512 ? w_color_512 : w_color_256;
        end
    end

    assign sram_addr = r_addr;
    assign coloridx  = r_color;
    assign borderx   = r_bdly[BORDER_DELAY-1];
    assign phase     = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_video_plane_fetch.sv
`default_nettype none
// ============================================================================
// tb_video_plane_fetch : randomized self-checking bench with event-level model
// Rev 1.0
// ============================================================================
module tb_video_plane_fetch;

    localparam int PLANES = 4;
    localparam int COLW   = 5;
    localparam int ROWW   = 8;
    localparam int HS_COL = 26;
    localparam int BDLY   = 4;
    localparam int GROUP  = 2 * PLANES;

    logic              clk24       = 1'b0;
    logic              reset_n     = 1'b0;
    logic              ce12        = 1'b0;
    logic              video_slice = 1'b0;
    logic              hsync_n     = 1'b1;
    logic [ROWW-1:0]   fb_row      = '0;
    logic              mode512     = 1'b0;
    logic [7:0]        sram_dq     = '0;
    logic [15:0]       sram_addr;
    logic [PLANES-1:0] coloridx;
    logic              borderx;
    logic              phase;

    video_plane_fetch #(
        .PLANES(PLANES), .COLW(COLW), .ROWW(ROWW),
        .HS_COL(HS_COL), .BORDER_DELAY(BDLY)
    ) dut (
        .clk24(clk24), .reset_n(reset_n), .ce12(ce12),
        .video_slice(video_slice), .hsync_n(hsync_n), .fb_row(fb_row),
        .mode512(mode512), .sram_dq(sram_dq), .sram_addr(sram_addr),
        .coloridx(coloridx), .borderx(borderx), .phase(phase)
    );

    always #5 clk24 = ~clk24;

    logic [7:0] mem [65536];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: slice count, column, bank contents as whole bytes
    int                m_slot, m_col, m_n;
    bit                m_phase, m_border, m_bx;
    bit                bq[$];
    logic [15:0]       m_addr;
    logic [PLANES-1:0] m_color;
    logic [7:0]        m_show [PLANES];
    logic [7:0]        m_pend [PLANES];

    function automatic logic pbit(input int p);
        if (p >= PLANES || m_n >= 8) return 1'b0;
        return m_show[p][7-m_n];
    endfunction

    function automatic void model_edge();
        bit toggle;
        if (!reset_n) begin
            m_slot = 0; m_col = 0; m_n = 0;
            m_phase = 0; m_border = 0; m_bx = 0;
            m_addr = '0; m_color = '0;
            for (int p = 0; p < PLANES; p++) begin
                m_show[p] = '0;
                m_pend[p] = '0;
            end
            bq.delete();
            for (int i = 0; i < BDLY; i++) bq.push_back(1'b0);
            return;
        end
        m_color = '0;
        if (!mode512) begin
            for (int p = 0; p < PLANES; p++) m_color[PLANES-1-p] = pbit(p);
        end else if (ce12 || PLANES == 2) begin
            m_color[1] = pbit(1);
            m_color[0] = pbit(0);
        end else begin
            m_color[1] = pbit(2);
            m_color[0] = pbit(3);
        end
        m_bx   = bq.pop_front();
        toggle = 0;
        if (video_slice) begin
            m_addr = 16'(32'h8000 + ((m_slot / 2) << (COLW + ROWW))
                          + (m_col << ROWW) + int'(fb_row));
            if (m_slot % 2 == 0) m_pend[m_slot/2] = mem[m_addr];
            if (m_slot == GROUP - 1) begin
                if (m_col == 0) m_border = ~m_border;
                m_col   = hsync_n ? (m_col + 1) % (1 << COLW) : HS_COL;
                m_phase = ~m_phase;
                toggle  = 1;
            end
            m_slot = (m_slot + 1) % GROUP;
        end
        if (toggle) begin
            m_show = m_pend;
            m_n    = 0;
        end else if (ce12 && m_n < 8) begin
            m_n++;
        end
        bq.push_back(m_border);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst_v, input logic slc_v, input logic hs_v,
                        input logic m5_v, input logic [7:0] row_v);
        reset_n     = rst_v;
        video_slice = slc_v;
        hsync_n     = hs_v;
        mode512     = m5_v;
        fb_row      = row_v;
        ce12        = ~ce12;
        @(posedge clk24);
        model_edge();
        #1;
        sram_dq = mem[sram_addr];
        chk("sram_addr", sram_addr, m_addr);
        chk("coloridx", 16'(coloridx), 16'(m_color));
        chk("borderx", 16'(borderx), 16'(m_bx));
        chk("phase", 16'(phase), 16'(m_phase));
    endtask

    initial begin
        logic [7:0] pat [4];
        logic [7:0] row;
        logic       m5;
        pat = '{8'h80, 8'h00, 8'hFF, 8'h01};
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int p = 0; p < PLANES; p++) mem[16'h8000 | 16'(p << 13) | 16'h005A] = pat[p];

        // reset held with slices running
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);

        // 256 mode, one slice per pixel clock: eight pixels per bank swap
        for (int i = 0; i < 4 * GROUP * 2; i++) step(1'b1, (i % 2) == 0, 1'b1, 1'b0, 8'h5A);

        // 512 mode, same cadence
        for (int i = 0; i < 3 * GROUP * 2; i++) step(1'b1, (i % 2) == 0, 1'b1, 1'b1, 8'h5A);

        // back-to-back slices with a new row
        for (int i = 0; i < 3 * GROUP; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'hC3);

        // hsync reload to HS_COL, then run through the column wrap
        for (int i = 0; i < GROUP; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        for (int i = 0; i < 8 * GROUP + 2 * BDLY; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h11);

        // slice gap: state must hold while shifters keep draining
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h22);
        repeat (5) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
        for (int i = 0; i < 2 * GROUP; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h22);

        // randomized traffic
        row = 8'h00;
        m5  = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (i % 64 == 0) begin
                m5  = 1'($urandom_range(0, 1));
                row = 8'($urandom);
            end
            step(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0, m5, row);
        end

        // mid-group reset, then recovery
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h33);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h33);
        for (int i = 0; i < 6 * GROUP; i++) step(1'b1, (i % 2) == 0, 1'b1, 1'b0, 8'h33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
